// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller: issues one instruction-memory read per
// instruction, captures the returned word and halts on a misaligned next PC.
// Optional stall-cycle counter enabled by defining FETCH_PERF_CNT_EN.
module pc_fetch_ctrl #(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_next_pc,
    input  logic              i_next_valid,
    input  logic              i_imem_stall,
    input  logic [31:0]       i_imem_data,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_imem_cen,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_inst,
    output logic              o_inst_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       o_stall_cycles,
`endif
    output logic              o_misalign
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_EXEC = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   load_inst;
    logic   load_pc;
    logic   set_misalign;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath load enables
    always_comb begin
        state_d      = state_q;
        load_inst    = 1'b0;
        load_pc      = 1'b0;
        set_misalign = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (!i_imem_stall) begin
                    state_d   = ST_EXEC;
                    load_inst = 1'b1;
                end
            end
            ST_EXEC: begin
                if (i_next_valid) begin
                    load_pc = 1'b1;
                    if (i_next_pc[1:0] == 2'b00) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d      = ST_HALT;
                        set_misalign = 1'b1;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs; the request strobe is aligned with the REQ state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pc         <= RESET_PC;
            o_imem_cen   <= 1'b0;
            o_inst       <= '0;
            o_inst_valid <= 1'b0;
            o_misalign   <= 1'b0;
        end else begin
            o_imem_cen   <= (state_d == ST_REQ);
            o_inst_valid <= load_inst;
            if (load_inst) begin
                o_inst <= i_imem_data;
            end
            if (load_pc) begin
                o_pc <= i_next_pc;
            end
            if (set_misalign) begin
                o_misalign <= 1'b1;
            end
        end
    end

    assign o_imem_addr = o_pc;

`ifdef FETCH_PERF_CNT_EN
    // Saturating count of cycles spent waiting on a stalled memory
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stall_cycles <= '0;
        end else if ((state_q == ST_WAIT) && i_imem_stall && (o_stall_cycles != 32'hFFFF_FFFF)) begin
            o_stall_cycles <= o_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, 64, width of PC and instruction-memory address.
REQ-002 Parameter RESET_PC, 0, PC value loaded on reset.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_next_pc  input  ADDR_W  next-PC value from the PC-select 2:1 mux.
REQ-006 i_next_valid  input  1  core signals that i_next_pc is final for the current instruction.
REQ-007 i_imem_stall  input  1  instruction memory busy; read data is not valid while high.
REQ-008 i_imem_data  input  32  instruction read data.
REQ-009 o_pc  output  ADDR_W  current PC register.
REQ-010 o_imem_cen  output  1  instruction-memory read request strobe.
REQ-011 o_imem_addr  output  ADDR_W  read address; equals o_pc.
REQ-012 o_inst  output  32  registered fetched instruction.
REQ-013 o_inst_valid  output  1  one-cycle pulse: o_inst is new.
REQ-014 o_misalign  output  1  sticky error: a loaded next PC had bits [1:0] != 0.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT, EXEC, HALT; reset state IDLE.
REQ-016 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-017 REQ SHALL drive o_imem_cen=1 for exactly one cycle with o_imem_addr=o_pc, then go to WAIT; o_imem_cen SHALL be 0 in every other state.
REQ-018 WAIT SHALL hold while i_imem_stall=1; on an edge with i_imem_stall=0 it SHALL load o_inst<=i_imem_data and enter EXEC.
REQ-019 o_inst_valid SHALL be 1 only in the first EXEC cycle; minimum REQ-to-o_inst_valid latency is 2 cycles.
REQ-020 o_inst SHALL hold its value until the next successful WAIT capture.
REQ-021 In EXEC, on an edge with i_next_valid=1, o_pc SHALL load i_next_pc; if i_next_pc[1:0]==0 the FSM SHALL go to REQ, otherwise to HALT with o_misalign<=1.
REQ-022 i_next_valid SHALL be ignored in IDLE, REQ, WAIT and HALT; o_pc changes only per REQ-021 or reset.
REQ-023 i_next_valid=1 in the same cycle as o_inst_valid SHALL be accepted (single-cycle EXEC).
REQ-024 HALT SHALL be terminal until reset: no requests, o_pc frozen, o_misalign held at 1.
REQ-025 PC arithmetic SHALL be ADDR_W wide with no carry-out; i_next_pc=2^ADDR_W-4 followed by 0 is legal wrap-around.

Reset
REQ-026 Asserting i_rst at any time, including mid-WAIT with a request outstanding, SHALL immediately force state IDLE, o_pc=RESET_PC, o_imem_cen=0, o_inst=0, o_inst_valid=0, o_misalign=0.
REQ-027 Read data arriving after reset assertion SHALL be discarded; the first post-reset request SHALL address RESET_PC.

Configuration
REQ-028 With macro FETCH_PERF_CNT_EN defined, the block SHALL add output o_stall_cycles (32 bits), which counts cycles spent in WAIT with i_imem_stall=1, saturates at 0xFFFFFFFF, and resets to 0.
REQ-029 Without FETCH_PERF_CNT_EN, o_stall_cycles and its counter SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-030 Reset release with stall=0 and i_imem_data=0x00000013 -> o_imem_cen at cycle 1 with addr 0, o_inst_valid at cycle 3 with o_inst=0x00000013.
REQ-031 i_imem_stall high for 5 cycles in WAIT -> no o_inst_valid during the stall, exactly one pulse after it; o_stall_cycles=5 if FETCH_PERF_CNT_EN is defined.
REQ-032 Sequence of i_next_pc 0x4, 0x8, 0x100 -> o_imem_addr follows 0x4, 0x8, 0x100; one request per instruction.
REQ-033 i_next_pc=0x102 -> o_pc=0x102, o_misalign=1, no further o_imem_cen until i_rst.
REQ-034 i_rst pulsed during WAIT, then stale data arrives -> o_inst stays 0, next request addr=RESET_PC.
REQ-035 i_next_valid held high through REQ/WAIT and i_next_pc=0xFFFFFFFFFFFFFFFC then 0x0 -> only EXEC-cycle samples load; PC wraps to 0 without error.
